nibble_serial_adder: RTL



---
 rtl/nibble_serial_adder_pkg.sv | 19 +
 rtl/nibble_add_slice.sv | 29 ++
 rtl/nibble_serial_adder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_pkg
// Description : Shared nibble width and FSM state encoding for the adder.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    // 2'b11 is unused; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_add_slice.sv
`default_nettype none
// ============================================================================
// Module      : nibble_add_slice
// Description : Purely combinational 4-bit ripple-carry adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_add_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NIB_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Multi-cycle WIDTH-bit adder reusing one 4-bit ripple slice,
//               one nibble per clock. Optional signed overflow output is
//               enabled with the NIBBLE_SERIAL_OVF_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NNIB  = WIDTH / 4
)(
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int                CNT_W = $clog2(NNIB);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NNIB - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [NIB_W-1:0]   w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_sr_next;

    nibble_add_slice u_slice (
        .a    (sa_q[NIB_W-1:0]),
        .b    (sb_q[NIB_W-1:0]),
        .cin  (carry_q),
        .s    (w_s),
        .cout (w_co)
    );

    // Each new sum nibble enters at the top, so after NNIB steps sr is in order.
    assign w_sr_next = {w_s, sr_q[WIDTH-1:NIB_W]};

`ifdef NIBBLE_SERIAL_OVF_EN
    logic w_c_msb;
    logic ovf_q, ovf_d;
    // Carry into the MSB recovered from the slice's top sum bit.
    assign w_c_msb = w_s[NIB_W-1] ^ sa_q[NIB_W-1] ^ sb_q[NIB_W-1];
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sr_d    = w_sr_next;
                carry_d = w_co;
                sa_d    = sa_q >> NIB_W;
                sb_d    = sb_q >> NIB_W;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = w_sr_next;
                    cout_d  = w_co;
`ifdef NIBBLE_SERIAL_OVF_EN
                    ovf_d   = w_c_msb ^ w_co;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign c_out = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
    assign overflow = ovf_q;
`endif

endmodule
`default_nettype wire
